// File: rtl/dynvc_buffer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dynvc_buffer_ctrl_if
// Description : Port bundle for the DynVC buffer pointer/free-list controller.
//               The slave modport is the controller; the master modport is the
//               flit-arrival / switch-allocation side driving push and pop.
// Revision    : 1.0 - initial release
// ============================================================================
interface dynvc_buffer_ctrl_if #(
    parameter int MAX_VC_NUMBER     = 10,
    parameter int MEMORY_BANK_DEPTH = 32
);
    localparam int POINTER_WIDTH = $clog2(MEMORY_BANK_DEPTH);
    localparam int COUNT_WIDTH   = $clog2(MEMORY_BANK_DEPTH + 1);

    logic [MAX_VC_NUMBER-1:0]             push_vc;
    logic [MAX_VC_NUMBER-1:0]             pop_vc;
    logic [MAX_VC_NUMBER-1:0]             push_ready;
    logic                                 write_en;
    logic [POINTER_WIDTH-1:0]             write_addr;
    logic                                 read_en;
    logic [POINTER_WIDTH-1:0]             read_addr;
    logic [MAX_VC_NUMBER-1:0]             vc_empty;
    logic [MAX_VC_NUMBER*COUNT_WIDTH-1:0] vc_count;
    logic [COUNT_WIDTH-1:0]               free_count;
    logic                                 error;

    modport master (
        output push_vc, pop_vc,
        input  push_ready, write_en, write_addr, read_en, read_addr,
               vc_empty, vc_count, free_count, error
    );

    modport slave (
        input  push_vc, pop_vc,
        output push_ready, write_en, write_addr, read_en, read_addr,
               vc_empty, vc_count, free_count, error
    );
endinterface
`default_nettype wire

// File: rtl/dynvc_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dynvc_buffer_ctrl
// Description : Pointer/free-list controller for the shared DynVC input buffer
//               bank. One next-pointer table holds a linked list per VC plus
//               the free list. At most one push and one pop per cycle.
//               Optional macro DYNVC_RESERVE_SLOT_EN guarantees each VC one
//               slot; when undefined the bank is fully shared.
// Revision    : 1.0 - initial release
// ============================================================================
module dynvc_buffer_ctrl #(
    parameter int MAX_VC_NUMBER     = 10,
    parameter int MEMORY_BANK_DEPTH = 32
) (
    input  wire logic          clk,
    input  wire logic          reset,
    dynvc_buffer_ctrl_if.slave bus
);
    localparam int POINTER_WIDTH = $clog2(MEMORY_BANK_DEPTH);
    localparam int COUNT_WIDTH   = $clog2(MEMORY_BANK_DEPTH + 1);
    localparam int VC_IDX_WIDTH  = (MAX_VC_NUMBER > 1) ? $clog2(MAX_VC_NUMBER) : 1;

    localparam logic [COUNT_WIDTH-1:0]   c_count_one = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0]   c_depth     = COUNT_WIDTH'(MEMORY_BANK_DEPTH);
    localparam logic [MAX_VC_NUMBER-1:0] c_vc_one    = MAX_VC_NUMBER'(1);

    // Bank depth must be a power of two so slot pointers cover it exactly.
    generate
        if ((MEMORY_BANK_DEPTH < 2) ||
            ((MEMORY_BANK_DEPTH & (MEMORY_BANK_DEPTH - 1)) != 0)) begin : g_depth_check
            $error("MEMORY_BANK_DEPTH must be a power of two and at least 2");
        end
    endgenerate

`ifdef DYNVC_RESERVE_SLOT_EN
    // Reserving a slot per VC is only possible when every VC can own one.
    generate
        if (MEMORY_BANK_DEPTH < MAX_VC_NUMBER) begin : g_reserve_check
            $error("MEMORY_BANK_DEPTH must be >= MAX_VC_NUMBER with slot reservation");
        end
    endgenerate
`endif

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [POINTER_WIDTH-1:0] r_next  [MEMORY_BANK_DEPTH];
    logic [POINTER_WIDTH-1:0] r_head  [MAX_VC_NUMBER];
    logic [POINTER_WIDTH-1:0] r_tail  [MAX_VC_NUMBER];
    logic [COUNT_WIDTH-1:0]   r_count [MAX_VC_NUMBER];
    logic [POINTER_WIDTH-1:0] r_free_head;
    logic [POINTER_WIDTH-1:0] r_free_tail;
    logic [COUNT_WIDTH-1:0]   r_free_count;
    logic                     r_error;

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    logic                     w_push_onehot;
    logic                     w_pop_onehot;
    logic [VC_IDX_WIDTH-1:0]  w_push_idx;
    logic [VC_IDX_WIDTH-1:0]  w_pop_idx;
    logic [MAX_VC_NUMBER-1:0] w_vc_empty;
    logic [MAX_VC_NUMBER-1:0] w_push_ready;
    logic                     w_push_ok;
    logic                     w_pop_ok;
    logic                     w_push_err;
    logic                     w_pop_err;
    logic                     w_same_single;
    logic [POINTER_WIDTH-1:0] w_read_addr;
`ifdef DYNVC_RESERVE_SLOT_EN
    logic [COUNT_WIDTH-1:0]   w_num_empty;
`endif

    // Decode one-hot requests, derive push readiness and accepted operations.
    always_comb begin
        w_push_onehot = (bus.push_vc != '0) &&
                        ((bus.push_vc & (bus.push_vc - c_vc_one)) == '0);
        w_pop_onehot  = (bus.pop_vc != '0) &&
                        ((bus.pop_vc & (bus.pop_vc - c_vc_one)) == '0);

        w_push_idx = '0;
        w_pop_idx  = '0;
        for (int v = 0; v < MAX_VC_NUMBER; v++) begin
            if (bus.push_vc[v]) w_push_idx = VC_IDX_WIDTH'(v);
            if (bus.pop_vc[v])  w_pop_idx  = VC_IDX_WIDTH'(v);
        end

        for (int v = 0; v < MAX_VC_NUMBER; v++) begin
            w_vc_empty[v] = (r_count[v] == '0);
        end

`ifdef DYNVC_RESERVE_SLOT_EN
        // A non-empty VC may only take a slot if every empty VC still has
        // one left to claim afterwards.
        w_num_empty = '0;
        for (int v = 0; v < MAX_VC_NUMBER; v++) begin
            w_num_empty = w_num_empty + COUNT_WIDTH'(w_vc_empty[v]);
        end
        for (int v = 0; v < MAX_VC_NUMBER; v++) begin
            if (w_vc_empty[v]) begin
                w_push_ready[v] = (r_free_count != '0);
            end else begin
                w_push_ready[v] = (r_free_count > w_num_empty);
            end
        end
`else
        w_push_ready = {MAX_VC_NUMBER{r_free_count != '0}};
`endif
        if (reset) begin
            w_push_ready = '0;
        end

        // Readiness is based on current occupancy only, so a slot freed by a
        // pop this cycle is never handed to a push in the same cycle.
        w_push_ok  = !reset && w_push_onehot && ((bus.push_vc & w_push_ready) != '0);
        w_pop_ok   = !reset && w_pop_onehot  && ((bus.pop_vc & ~w_vc_empty) != '0);
        w_push_err = !reset && (bus.push_vc != '0) && !w_push_ok;
        w_pop_err  = !reset && (bus.pop_vc  != '0) && !w_pop_ok;

        // Same VC pushes and pops its only flit: the new slot becomes head.
        w_same_single = w_push_ok && w_pop_ok && (bus.push_vc == bus.pop_vc) &&
                        (r_count[w_push_idx] == c_count_one);

        w_read_addr = r_head[w_pop_idx];
    end

    // Drive bank strobes/addresses and status outputs.
    always_comb begin
        bus.push_ready = w_push_ready;
        bus.write_en   = w_push_ok;
        bus.write_addr = reset ? '0 : r_free_head;
        bus.read_en    = w_pop_ok;
        bus.read_addr  = reset ? '0 : w_read_addr;
        bus.vc_empty   = w_vc_empty;
        bus.vc_count   = '0;
        for (int v = 0; v < MAX_VC_NUMBER; v++) begin
            bus.vc_count[(MAX_VC_NUMBER-1-v)*COUNT_WIDTH +: COUNT_WIDTH] = r_count[v];
        end
        bus.free_count = r_free_count;
        bus.error      = r_error;
    end

    // Linked-list, free-list, occupancy and sticky-error state update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEMORY_BANK_DEPTH; i++) begin
                r_next[i] <= POINTER_WIDTH'((i + 1) % MEMORY_BANK_DEPTH);
            end
            for (int v = 0; v < MAX_VC_NUMBER; v++) begin
                r_head[v]  <= '0;
                r_tail[v]  <= '0;
                r_count[v] <= '0;
            end
            r_free_head  <= '0;
            r_free_tail  <= POINTER_WIDTH'(MEMORY_BANK_DEPTH - 1);
            r_free_count <= c_depth;
            r_error      <= 1'b0;
        end else begin
            if (w_push_err || w_pop_err) begin
                r_error <= 1'b1;
            end

            // Pop: advance the VC head and append the slot to the free list.
            // With an empty free list the old free tail is stale, so it is
            // not linked; the popped slot simply becomes the whole list.
            if (w_pop_ok) begin
                r_head[w_pop_idx] <= r_next[w_read_addr];
                if (r_free_count != '0) begin
                    r_next[r_free_tail] <= w_read_addr;
                end
                r_free_tail <= w_read_addr;
            end

            // Push: link free_head behind the VC tail (or make it the head).
            // Placed after the pop so its head write wins for w_same_single.
            if (w_push_ok) begin
                if (w_vc_empty[w_push_idx] || w_same_single) begin
                    r_head[w_push_idx] <= r_free_head;
                end else begin
                    r_next[r_tail[w_push_idx]] <= r_free_head;
                end
                r_tail[w_push_idx] <= r_free_head;
            end

            // Free head: refill from the popped slot when the list runs dry.
            if (w_pop_ok && (r_free_count == '0)) begin
                r_free_head <= w_read_addr;
            end else if (w_push_ok && w_pop_ok && (r_free_count == c_count_one)) begin
                r_free_head <= w_read_addr;
            end else if (w_push_ok) begin
                r_free_head <= r_next[r_free_head];
            end

            if (w_push_ok && !w_pop_ok) begin
                r_free_count <= r_free_count - c_count_one;
            end else if (w_pop_ok && !w_push_ok) begin
                r_free_count <= r_free_count + c_count_one;
            end

            for (int v = 0; v < MAX_VC_NUMBER; v++) begin
                if (w_push_ok && bus.push_vc[v] && !(w_pop_ok && bus.pop_vc[v])) begin
                    r_count[v] <= r_count[v] + c_count_one;
                end else if (w_pop_ok && bus.pop_vc[v] && !(w_push_ok && bus.push_vc[v])) begin
                    r_count[v] <= r_count[v] - c_count_one;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dynvc_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dynvc_buffer_ctrl
// Description : Directed self-checking bench for dynvc_buffer_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dynvc_buffer_ctrl;
    localparam int NVC   = 10;
    localparam int DEPTH = 32;
    localparam int CW    = 6;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    dynvc_buffer_ctrl_if #(.MAX_VC_NUMBER(NVC), .MEMORY_BANK_DEPTH(DEPTH)) bus();

    dynvc_buffer_ctrl #(.MAX_VC_NUMBER(NVC), .MEMORY_BANK_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NVC-1:0] oh(input int v);
        logic [NVC-1:0] one;
        one = 1;
        return one << v;
    endfunction

    function automatic int cnt(input int v);
        return int'(bus.vc_count[(NVC-1-v)*CW +: CW]);
    endfunction

    function automatic int occupancy_sum();
        int s;
        s = int'(bus.free_count);
        for (int v = 0; v < NVC; v++) s += cnt(v);
        return s;
    endfunction

    // Apply push/pop requests mid-cycle; combinational outputs settle after #1.
    task automatic drive(input logic [NVC-1:0] pv, input logic [NVC-1:0] qv);
        @(negedge clk);
        bus.push_vc = pv;
        bus.pop_vc  = qv;
        #1;
    endtask

    // Let the clock edge take effect, then release the request lines.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.push_vc = '0;
        bus.pop_vc  = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic push_n(input int v, input int n);
        for (int i = 0; i < n; i++) begin
            drive(oh(v), '0);
            tick();
        end
    endtask

    initial begin
        bus.push_vc = '0;
        bus.pop_vc  = '0;

        // Reset: requests are blocked and state comes up clean.
        reset = 1'b1;
        drive(oh(0), '0);
        check("rst_write_en", bus.write_en, 0);
        check("rst_push_ready", bus.push_ready, 0);
        tick();
        tick();
        reset = 1'b0;
        check("rst_free_count", bus.free_count, 32);
        check("rst_vc_empty", bus.vc_empty, 10'h3FF);
        check("rst_error", bus.error, 0);
        check("rst_count0", cnt(0), 0);

        // Three pushes to VC0.
        for (int i = 0; i < 3; i++) begin
            drive(oh(0), '0);
            check("push0_wen", bus.write_en, 1);
            check("push0_waddr", bus.write_addr, i);
            tick();
        end
        check("push0_count", cnt(0), 3);
        check("push0_free", bus.free_count, 29);
        check("push0_empty", bus.vc_empty[0], 0);

        // Pop them back in FIFO order.
        for (int i = 0; i < 3; i++) begin
            drive('0, oh(0));
            check("pop0_ren", bus.read_en, 1);
            check("pop0_raddr", bus.read_addr, i);
            tick();
        end
        check("pop0_empty", bus.vc_empty[0], 1);
        check("pop0_free", bus.free_count, 32);

        // Freed slots 0..2 come back only after slots 3..31.
        for (int i = 0; i < 29; i++) begin
            drive(oh(1), '0);
            check("reuse_waddr", bus.write_addr, 3 + i);
            tick();
        end
        drive(oh(1), '0);
        check("reuse_wrap", bus.write_addr, 0);
        tick();
        check("reuse_free", bus.free_count, 2);
        check("reuse_inv", occupancy_sum(), 32);

        // Interleave VC2/VC5, then drain VC5.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(oh((i % 2 == 0) ? 2 : 5), '0);
            check("ilv_waddr", bus.write_addr, i);
            tick();
        end
        drive('0, oh(5));
        check("ilv_pop5a", bus.read_addr, 1);
        tick();
        drive('0, oh(5));
        check("ilv_pop5b", bus.read_addr, 3);
        tick();
        check("ilv_count5", cnt(5), 0);
        check("ilv_count2", cnt(2), 2);
        drive('0, oh(2));
        check("ilv_pop2", bus.read_addr, 0);
        tick();
        check("ilv_free", bus.free_count, 31);

        // Full bank: push blocked even with a simultaneous pop.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            drive(oh(1), '0);
            check("fill_waddr", bus.write_addr, i);
            tick();
        end
        check("full_ready", bus.push_ready, 0);
        check("full_free", bus.free_count, 0);
        check("full_error", bus.error, 0);
        drive(oh(1), oh(1));
        check("full_wen", bus.write_en, 0);
        check("full_ren", bus.read_en, 1);
        check("full_raddr", bus.read_addr, 0);
        tick();
        check("full_err_set", bus.error, 1);
        check("full_free1", bus.free_count, 1);
        check("full_count1", cnt(1), 31);
        drive(oh(1), '0);
        check("refill_wen", bus.write_en, 1);
        check("refill_waddr", bus.write_addr, 0);
        tick();
        check("refill_free", bus.free_count, 0);
        check("refill_count", cnt(1), 32);
        drive('0, oh(1));
        check("refill_pop", bus.read_addr, 1);
        tick();
        check("refill_inv", occupancy_sum(), 32);

        // VC3 single flit with one free slot: push and pop together.
        do_reset();
        push_n(3, 1);
        push_n(1, 30);
        check("one_free", bus.free_count, 1);
        drive(oh(3), oh(3));
        check("pp_wen", bus.write_en, 1);
        check("pp_ren", bus.read_en, 1);
        check("pp_raddr", bus.read_addr, 0);
        check("pp_waddr", bus.write_addr, 31);
        tick();
        check("pp_count3", cnt(3), 1);
        check("pp_free", bus.free_count, 1);
        drive('0, oh(3));
        check("pp_newhead", bus.read_addr, 31);
        tick();
        drive(oh(1), '0);
        check("pp_freehead", bus.write_addr, 0);
        tick();
        check("pp_error", bus.error, 0);

        // Pop of an empty VC is ignored and flagged.
        drive('0, oh(4));
        check("empty_ren", bus.read_en, 0);
        tick();
        check("empty_err", bus.error, 1);
        check("empty_free", bus.free_count, 1);
        check("empty_count4", cnt(4), 0);

        // Multi-hot push and pop are ignored and flagged.
        do_reset();
        drive(oh(0) | oh(1), '0);
        check("mh_push_wen", bus.write_en, 0);
        tick();
        check("mh_push_err", bus.error, 1);
        check("mh_push_free", bus.free_count, 32);
        do_reset();
        push_n(2, 1);
        drive('0, oh(2) | oh(3));
        check("mh_pop_ren", bus.read_en, 0);
        tick();
        check("mh_pop_count", cnt(2), 1);
        check("mh_pop_err", bus.error, 1);

        // Readiness with VC0 holding 23 slots and 9 free.
        do_reset();
        push_n(0, 23);
        check("rsv_free", bus.free_count, 9);
`ifdef DYNVC_RESERVE_SLOT_EN
        check("rsv_ready", bus.push_ready, 10'h3FE);
`else
        check("rsv_ready", bus.push_ready, 10'h3FF);
`endif
        check("rsv_inv", occupancy_sum(), 32);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dynvc_buffer_ctrl.md
Name: dynvc_buffer_ctrl

Overview:
Pointer/free-list controller for the shared DynVC input buffer bank. It keeps a per-VC linked list of occupied slots and a linked free list in one next-pointer table, and drives the bank's write and read addresses. It sits between the input port's flit arrival/VC-allocation logic and the memory bank, and exports occupancy and ready status to credit and switch-allocation logic. It accepts at most one push and one pop per cycle.

Parameters:
max_vc_number, 10, number of VCs sharing the bank
memory_bank_depth, 32, slots in the bank (power of 2, >=2)
pointer_width, clogb(memory_bank_depth), derived slot address width (localparam)
count_width, clogb(memory_bank_depth+1), derived occupancy counter width (localparam)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
push_vc  in  max_vc_number  one-hot VC receiving a flit this cycle; all-zero = no push
pop_vc  in  max_vc_number  one-hot VC whose head flit is read this cycle; all-zero = no pop
push_ready  out  max_vc_number  per-VC push acceptance for the current cycle
write_en  out  1  bank write strobe (accepted push)
write_addr  out  pointer_width  bank slot to write
read_en  out  1  bank read strobe (accepted pop)
read_addr  out  pointer_width  bank slot to read; bank data returns one cycle later
vc_empty  out  max_vc_number  per-VC empty flags
vc_count  out  max_vc_number*count_width  per-VC occupancy, VC0 in MSBs
free_count  out  count_width  free slots
error  out  1  sticky protocol-violation flag

Behaviour:
- One clock, clk; reset synchronous active-high; all state updates on posedge clk.
- After reset: next[i]=i+1 (wraps to 0 for the last entry), free_head=0, free_tail=depth-1, free_count=depth, all vc_count=0, vc_empty all 1, error=0, head/tail registers 0.
- write_en, write_addr, read_en, read_addr, and push_ready are combinational from current state and inputs. All are 0 while reset is high.
- Accepted push = push_vc!=0 and push_ready[vc]=1.
  - write_addr=free_head.
  - If the VC is empty, or it pops its only flit this cycle: head[vc]<=write_addr. Otherwise next[tail[vc]]<=write_addr.
  - tail[vc]<=write_addr; count[vc]+1.
- Accepted pop = pop_vc!=0 and vc_empty[vc]=0.
  - read_addr=head[vc]; head[vc]<=next[head[vc]].
  - The slot is appended to the free list: next[free_tail]<=read_addr, free_tail<=read_addr; count[vc]-1.
- Free-list corner cases:
  - Pop with free_count==0: free_head<=free_tail<=read_addr.
  - Push and pop with free_count==1: free_head<=read_addr.
  - Otherwise a push advances free_head<=next[free_head].
- free_count updates by (+pop -push); simultaneous push and pop leave it unchanged.
- Both next-table writes target distinct entries, because a VC tail and the free tail are never the same slot.
- A push cannot use a slot freed in the same cycle (free_count==0 blocks the push even with a pop that cycle).
- Violations set error and are ignored with no state change:
  - pop of an empty VC;
  - push while push_ready is 0;
  - push_vc or pop_vc with more than one bit set.
- error clears only on reset.
- Reset asserted mid-operation discards all lists and restores the reset state in the following cycle.
- Invariant: sum(vc_count)+free_count == memory_bank_depth at all times.

Optional Feature:
DYNVC_RESERVE_SLOT_EN
- Defined: each VC is guaranteed one slot.
  - push_ready[v]=1 if count[v]==0 and free_count>0.
  - Otherwise push_ready[v]=(free_count > number of VCs other than v with count==0).
  - Requires memory_bank_depth >= max_vc_number (elaboration-time check).
- Undefined: push_ready[v]=(free_count!=0) for every v, so the bank is fully shared.

Test Plan:
- Reset, then push VC0 three times, no pops -> write_addr 0,1,2; vc_count[0]=3; free_count=29; vc_empty[0]=0.
- Then pop VC0 three times -> read_addr 0,1,2 in order; vc_empty[0]=1; free_count=32; freed slots reused after slots 3..31.
- Interleave pushes to VC2/VC5 (A,B,A,B), then pop VC5 twice -> read_addr returns VC5's slots 1 and 3 in FIFO order; VC2 unaffected.
- Fill all 32 slots with pushes to VC1 -> push_ready all 0. Push plus pop of VC1 in the same cycle -> push rejected, error=1, free_count=1. Next cycle a push to VC1 -> accepted at the freed slot, free_count=0.
- VC3 count=1, free_count=1, push and pop VC3 same cycle -> read_addr=old head, head=tail=write_addr, count stays 1, free_head=popped slot.
- Pop empty VC4 -> read_en=0, error=1, no counter change. With DYNVC_RESERVE_SLOT_EN defined, VC0 holds 23 and free_count=9 -> push_ready[0]=0, push_ready[1..9]=1.
